// File: rtl/clever_cache_ram.sv
// -----------------------------------------------------------------------------
// clever_cache_ram
//   A word-addressed backing RAM in front of which sits a direct-mapped,
//   one-word-per-line read cache. Reads that hit complete in one cycle. Read
//   misses and all writes take RAM_LATENCY-1 edges from accept to completion.
//   Writes are write-through / no-write-allocate.
//
// Ports
//   clk       single rising-edge clock
//   rst_n     asynchronous active-low reset (RAM contents are not touched)
//   req       request valid, accepted only while busy = 0
//   mode      1 = write to RAM, 0 = read through cache
//   address   word address, only the low log2(RAM_WORDS) bits are used
//   data      write data, ignored for reads
//   out       last read result (registered)
//   response  one-cycle completion pulse per accepted request
//   busy      high while a multi-cycle request is in flight
// -----------------------------------------------------------------------------
module clever_cache_ram #(
  parameter int RAM_WORDS   = 256,
  parameter int CACHE_LINES = 8,
  parameter int RAM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        mode,
  input  logic [31:0] address,
  input  logic [31:0] data,
  output logic [31:0] out,
  output logic        response,
  output logic        busy
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int IW = $clog2(CACHE_LINES);
  localparam int TW = AW - IW;
  localparam int CW = (RAM_LATENCY > 2) ? $clog2(RAM_LATENCY) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t state, state_n;

  // Backing store: zero at power-up, never cleared by rst_n.
  logic [31:0] ram [RAM_WORDS] = '{default: '0};

  // Cache line storage.
  logic [CACHE_LINES-1:0] line_valid;
  logic [TW-1:0]          line_tag  [CACHE_LINES];
  logic [31:0]            line_data [CACHE_LINES];

  // Request captured at accept; the live inputs are ignored during WAIT.
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
  logic          mode_q;
  logic [CW-1:0] cnt;

  // Upper address bits fall outside the RAM and wrap away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address[31:AW];

  logic [IW-1:0] idx_in, idx_q;
  logic [TW-1:0] tag_in, tag_q;
  logic          accept, rd_hit, start_wait, done, wr_hit;

  assign idx_in = address[IW-1:0];
  assign tag_in = address[AW-1:IW];
  assign idx_q  = addr_q[IW-1:0];
  assign tag_q  = addr_q[AW-1:IW];

  assign accept     = req && (state == S_IDLE);
  assign rd_hit     = accept && !mode && line_valid[idx_in] && (line_tag[idx_in] == tag_in);
  assign start_wait = accept && !rd_hit;
  assign done       = (state == S_WAIT) && (cnt == '0);
  // Write hit is evaluated at completion against the line as it is then.
  assign wr_hit     = line_valid[idx_q] && (line_tag[idx_q] == tag_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // FSM: next state
  // NOTE: state_n gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start_wait) state_n = S_WAIT;
      S_WAIT: if (cnt == '0)  state_n = S_IDLE;
      default:                state_n = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state == S_WAIT);
  end

  // ---------------------------------------------------------------------------
  // Control and result registers (reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      mode_q     <= 1'b0;
      out        <= '0;
      response   <= 1'b0;
      line_valid <= '0;
    end else begin
      response <= rd_hit || done;

      // Counter loaded so completion lands RAM_LATENCY-1 edges after accept.
      if (start_wait) begin
        cnt    <= CW'(RAM_LATENCY - 2);
        addr_q <= address[AW-1:0];
        data_q <= data;
        mode_q <= mode;
      end else if ((state == S_WAIT) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end

      if (rd_hit) out <= line_data[idx_in];

      if (done && !mode_q) begin
        out               <= ram[addr_q];
        line_valid[idx_q] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Storage arrays (no reset)
  // ---------------------------------------------------------------------------
  // NOTE: RAM and line tag/data arrays are deliberately not reset; line_valid
  // alone gates their use, and the RAM must survive rst_n. A reset on an array
  // also prevents mapping it onto memory macros.
  always_ff @(posedge clk) begin
    if (done && mode_q) ram[addr_q] <= data_q;

    // Read miss fills the line; write updates it only on a hit.
    if (done && (!mode_q || wr_hit)) begin
      line_tag[idx_q]  <= tag_q;
      line_data[idx_q] <= mode_q ? data_q : ram[addr_q];
    end
  end

endmodule

// File: tb/tb_clever_cache_ram.sv
// -----------------------------------------------------------------------------
// tb_clever_cache_ram
//   Directed stimulus pushes the expected read value and completion cycle of
//   every request into a scoreboard queue; an independent monitor pops and
//   compares on each response pulse. Inputs are driven at negedge+1, outputs
//   sampled at the negedge.
// -----------------------------------------------------------------------------
module tb_clever_cache_ram;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data = '0;
  logic [31:0] out;
  logic        response;
  logic        busy;

  clever_cache_ram #(
    .RAM_WORDS   (256),
    .CACHE_LINES (8),
    .RAM_LATENCY (LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .mode     (mode),
    .address  (address),
    .data     (data),
    .out      (out),
    .response (response),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp_out;
    int          exp_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_issued = 0;
  int   n_resp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (response === 1'b1) begin
      n_resp++;
      if (sb_q.size() == 0) begin
        check("spurious_response", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, "_out"}, out, mon_e.exp_out);
        check({mon_e.name, "_latency"}, cyc, mon_e.exp_cyc);
      end
    end
  end

  // Issue one request (called at negedge+1) and wait for its completion.
  task automatic issue(input string name, input bit m, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_out,
                       input bit hit, input bit poke_busy);
    exp_t e;
    e.name    = name;
    e.exp_out = exp_out;
    e.exp_cyc = hit ? cyc + 1 : cyc + LAT;
    sb_q.push_back(e);
    n_issued++;
    req = 1'b1; mode = m; address = a; data = d;
    @(negedge clk); #1;
    // Scramble inputs after accept: the captured request must be used.
    req = 1'b0; mode = ~m; address = ~a; data = ~d;
    check({name, "_busy"}, {31'd0, busy}, hit ? 32'd0 : 32'd1);
    if (poke_busy) begin
      req = 1'b1;
      @(negedge clk); #1;
      req = 1'b0;
    end
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb_q.size() != 0) begin
      check({name, "_timeout"}, sb_q.size(), 32'd0);
      sb_q.delete();
    end
    check({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_out", out, 32'd0);
    check("rst_resp", {31'd0, response}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // Cold read miss, accepted at the first edge after reset release.
    issue("rd5_cold", 1'b0, 32'd5, 32'd0, 32'h0000_0000, 1'b0, 1'b0);

    // Fresh cache (RAM keeps its contents).
    rst_n = 1'b0; #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Write miss does not allocate; out unchanged.
    issue("wr5_dead",    1'b1, 32'd5, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0);
    issue("rd5_noalloc", 1'b0, 32'd5, 32'd0,         32'hDEAD_BEEF, 1'b0, 1'b0);
    issue("rd5_hit",     1'b0, 32'd5, 32'd0,         32'hDEAD_BEEF, 1'b1, 1'b0);
    // Write hit updates the line.
    issue("wr5_1234",    1'b1, 32'd5, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b0);
    issue("rd5_upd",     1'b0, 32'd5, 32'd0,         32'h1234_5678, 1'b1, 1'b0);
    // Same-index conflict: 13 evicts 5, then 5 refills from RAM.
    issue("wr13",        1'b1, 32'd13, 32'hCAFE_F00D, 32'h1234_5678, 1'b0, 1'b0);
    issue("rd13_evict",  1'b0, 32'd13, 32'd0,         32'hCAFE_F00D, 1'b0, 1'b0);
    issue("rd5_refill",  1'b0, 32'd5,  32'd0,         32'h1234_5678, 1'b0, 1'b0);
    // Wrapping address, with a req pulse while busy that must be ignored.
    issue("wr105",       1'b1, 32'h105, 32'hA5A5_A5A5, 32'h1234_5678, 1'b0, 1'b1);
    issue("rd5_wrap",    1'b0, 32'd5,   32'd0,         32'hA5A5_A5A5, 1'b1, 1'b0);
    issue("rd_hiaddr",   1'b0, 32'hFFFF_FF05, 32'd0,   32'hA5A5_A5A5, 1'b1, 1'b0);
    issue("rd_ff",       1'b0, 32'hFF,  32'd0,         32'h0000_0000, 1'b0, 1'b0);
    issue("rd5_pre",     1'b0, 32'd5,   32'd0,         32'hA5A5_A5A5, 1'b1, 1'b0);

    // Reset in the middle of a write: aborted, never committed.
    req = 1'b1; mode = 1'b1; address = 32'd7; data = 32'h0000_0001;
    @(negedge clk); #1;
    req = 1'b0;
    @(negedge clk); #1;
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0; #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_out", out, 32'd0);
    check("abort_resp", {31'd0, response}, 32'd0);
    repeat (4) @(negedge clk);
    #1;
    rst_n = 1'b1;
    issue("rd7_after_abort", 1'b0, 32'd7, 32'd0, 32'h0000_0000, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("resp_count", n_resp, n_issued);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
